gdiv_seq: RTL

Run controller for the team's unary saturating-counter divider. It accepts a pair of binary operands with a start/busy/done handshake, generates the dividend and divisor bitstreams, and runs an internal divider core through a warm-up phase and then a fixed-length measurement phase. It counts quotient ones into a binary result. It sits between binary control logic and the stochastic divider datapath, and owns all sequencing, random sources and operand validation.

---
 rtl/gdiv_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gdiv_seq.sv
// Run controller for the unary saturating-counter divider: operand handshake,
// bitstream generation, warm-up and fixed-length measurement of the quotient stream.
module gdiv_seq #(
    parameter int WIDTH   = 4,
    parameter int LEN_LOG = 8,
    parameter int WARM    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend_bin,
    input  logic [WIDTH-1:0]   divisor_bin,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LEN_LOG:0]   quotient_bin
);

    generate
        if (!(WIDTH == 4 || WIDTH == 8)) begin : g_bad_width
            $error("gdiv_seq: WIDTH must be 4 or 8");
        end
        if (LEN_LOG < WIDTH || WARM < 1 || WARM > (1 << LEN_LOG)) begin : g_bad_len
            $error("gdiv_seq: illegal LEN_LOG/WARM");
        end
    endgenerate

    // Feedback taps: x^4+x^3+1 -> bits 3,2; x^8+x^6+x^5+x^4+1 -> bits 7,5,4,3
    localparam int                 TAPS_I    = (WIDTH == 8) ? 'hB8 : 'hC;
    localparam logic [WIDTH-1:0]   TAPS      = TAPS_I[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   C_MID     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   LFSR_SEED = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_LOG:0]   Q_SAT     = {1'b1, {LEN_LOG{1'b0}}};
    localparam logic [LEN_LOG-1:0] WARM_LAST = LEN_LOG'(WARM - 1);

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     dvd_q, dvs_q;
    logic [LEN_LOG-1:0]   ctr_q, ctr_d;
    logic [WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [WIDTH-1:0]     c_q, c_d;
    logic [LEN_LOG:0]     acc_q, acc_d;
    logic                 busy_q, done_q, err_q;
    logic [LEN_LOG:0]     quot_q;

    logic [WIDTH-1:0]     rng_a, rng_b;
    logic                 bit_a, bit_b, q, inc, dec, ops_ok;

    assign rng_a = ctr_q[WIDTH-1:0];

    always_comb begin
        rng_b = '0;
        for (int i = 0; i < WIDTH; i++) rng_b[i] = ctr_q[WIDTH-1-i];
    end

    assign bit_a  = dvd_q > rng_a;
    assign bit_b  = dvs_q > rng_b;
    assign q      = c_q >= lfsr_q;
    assign inc    = bit_a;
    assign dec    = q & bit_b;
    assign ops_ok = (divisor_bin != '0) && (dividend_bin <= divisor_bin);

    // Saturating core counter: simultaneous inc/dec cancel out
    always_comb begin
        c_d = c_q;
        if (inc && !dec && c_q != '1)
            c_d = c_q + 1'b1;
        else if (dec && !inc && c_q != '0)
            c_d = c_q - 1'b1;
    end

    assign lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign ctr_d  = ctr_q + 1'b1;
    assign acc_d  = acc_q + (LEN_LOG+1)'(q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            ctr_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            c_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            quot_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (ops_ok) begin
                            dvd_q   <= dividend_bin;
                            dvs_q   <= divisor_bin;
                            ctr_q   <= '0;
                            lfsr_q  <= LFSR_SEED;
                            c_q     <= C_MID;
                            acc_q   <= '0;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_WARM;
                        end else begin
                            err_q   <= 1'b1;
                            quot_q  <= Q_SAT;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WARM: begin
                    lfsr_q <= lfsr_d;
                    c_q    <= c_d;
                    if (ctr_q == WARM_LAST) begin
                        ctr_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        ctr_q <= ctr_d;
                    end
                end
                S_RUN: begin
                    lfsr_q <= lfsr_d;
                    c_q    <= c_d;
                    ctr_q  <= ctr_d;
                    acc_q  <= acc_d;
                    if (ctr_q == '1) begin
                        quot_q  <= acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign quotient_bin = quot_q;

endmodule
